iq_merge: RTL
=============

// Module: iq_merge
// PURPOSE
//  Receive-side counterpart of the QPSK I/Q splitter. Takes one decided symbol per
//  pulse (bipolar I/Q codes) from the sampling/decision stage, buffers it in a
//  4-deep FIFO, and re-serialises it as Q bit then I bit. Each bit is held for
//  BIT_CYCLES clocks (5 kb/s at 50 MHz). Drives the recovered serial data to the sink.
// PARAMETERS
//  BIT_CYCLES  14'd10000  clocks per output bit (IQ_DIV_MAX*BIT_SAMPLE); legal 2..16383
//  FIFO_AW     2          FIFO address width; depth = 2**FIFO_AW = 4 symbols
// PORTS
//  clk        in   1   system clock, 50 MHz
//  rst_n      in   1   asynchronous, active-low reset
//  sym_valid  in   1   1-cycle pulse: I_dec/Q_dec hold a new symbol
//  I_dec      in   2   bipolar I code: 2'b01=+1 (bit 1), 2'b11=-1 (bit 0)
//  Q_dec      in   2   bipolar Q code, same coding
//  ser_o      out  1   recovered serial bit, Q first then I
//  ser_valid  out  1   high while ser_o carries a bit
//  bit_strobe out  1   1-cycle pulse on the first clock of every output bit
//  ovf        out  1   sticky: a symbol was dropped because the FIFO was full
//  err_cnt    out  8   count of invalid codes seen (ERR_CHK_EN only, else 0)
// BEHAVIOUR
//  - Reset (async, any time, incl. mid-bit): FIFO emptied, FSM->IDLE, bit counter=0;
//    ser_o=0, ser_valid=0, bit_strobe=0, ovf=0, err_cnt=0. All outputs registered.
//  - Bit mapping: bit = ~code[1] (01->1, 11->0). FIFO entry = {q_bit, i_bit}.
//  - FIFO write on sym_valid when count<depth. Occupancy tracked by a count register.
//    Write and pop in the same cycle: accepted even when full, count unchanged.
//    Write while full with no pop: symbol dropped, ovf<=1 (cleared only by reset).
//  - FSM states IDLE, OUT_Q, OUT_I; 14-bit counter bit_cnt 0..BIT_CYCLES-1.
//    IDLE: ser_valid=0, ser_o=0. If FIFO non-empty: pop; next state OUT_Q.
//      On that edge: ser_o<=q_bit, ser_valid<=1, bit_strobe<=1, bit_cnt<=0.
//    OUT_Q: bit_cnt++. At BIT_CYCLES-1: ser_o<=i_bit, bit_strobe<=1, bit_cnt<=0, ->OUT_I.
//    OUT_I: bit_cnt++. At BIT_CYCLES-1: if FIFO non-empty, pop, load next q_bit,
//      pulse bit_strobe, ->OUT_Q (gapless). Else ser_valid<=0, ser_o<=0, ->IDLE.
//  - Latency: sym_valid sampled at edge N (idle, empty FIFO) -> ser_o/ser_valid/
//    bit_strobe valid after edge N+2. Each symbol occupies exactly 2*BIT_CYCLES clocks.
//  - Popped symbol held in a 2-bit holding register; I bit comes from it, not FIFO.
//  - sym_valid ignored during reset; a sym_valid wider than 1 cycle writes once per cycle.
// CONFIGURATION
//  ERR_CHK_EN defined: codes 2'b00/2'b10 on I_dec or Q_dec with sym_valid are
//    invalid. The symbol is not written and ovf is not affected. err_cnt increments
//    by 1 per invalid symbol and saturates at 8'hFF.
//  ERR_CHK_EN undefined: no checking; all codes mapped by ~code[1]; err_cnt tied 8'h00.
// TESTING (sim with BIT_CYCLES=10)
//  1 Assert rst_n=0 -> ser_o=0, ser_valid=0, bit_strobe=0, ovf=0, err_cnt=0.
//  2 One sym_valid with I=01, Q=11 -> after 2 clk: ser_o=0 for 10 clk, then ser_o=1
//    for 10 clk; strobes at clk 0 and 10; ser_valid falls after clk 20.
//  3 Symbols every 20 clk: (I,Q)=(01,01),(11,01),(01,11) -> ser_o 1,1,1,0,0,1
//    per 10-clk bit, ser_valid continuously 1, no gap.
//  4 Six sym_valid on consecutive clocks while idle -> 5 accepted (1 popped + 4 stored),
//    6th dropped, ovf=1. Exactly 10 bits are output, then IDLE.
//  5 (ERR_CHK_EN) sym_valid with I=00 -> no output, err_cnt=1. 300 invalid symbols ->
//    err_cnt=8'hFF. Without the macro, I=00 gives i_bit=1 and err_cnt stays 0.
//  6 Pull rst_n low mid-OUT_Q with 2 symbols queued -> outputs 0 at once. After release,
//    a new symbol is output normally with no stale bits.

Source files
------------

// File: rtl/iq_merge_if.sv
// Symbol-in / serial-out bundle for iq_merge: decision stage drives the master side,
// the merger sits on the slave side.
interface iq_merge_if;
    logic       sym_valid;
    logic [1:0] I_dec;
    logic [1:0] Q_dec;
    logic       ser_o;
    logic       ser_valid;
    logic       bit_strobe;
    logic       ovf;
    logic [7:0] err_cnt;

    modport master (
        output sym_valid, I_dec, Q_dec,
        input  ser_o, ser_valid, bit_strobe, ovf, err_cnt
    );

    modport slave (
        input  sym_valid, I_dec, Q_dec,
        output ser_o, ser_valid, bit_strobe, ovf, err_cnt
    );
endinterface

// File: rtl/iq_merge.sv
// QPSK I/Q merger: buffers decided symbols in a small FIFO and re-serialises them
// Q bit first, then I bit. Optional code checking enabled by defining ERR_CHK_EN.
module iq_merge #(
    parameter logic [13:0] BIT_CYCLES = 14'd10000,
    parameter int unsigned FIFO_AW    = 2
) (
    input logic       clk,
    input logic       rst_n,
    iq_merge_if.slave bus
);
    localparam int unsigned DEPTH = 1 << FIFO_AW;
    localparam int unsigned CW    = FIFO_AW + 1;

    typedef enum logic [1:0] {IDLE, OUT_Q, OUT_I} state_t;

    state_t              state;
    state_t              state_nxt;
    logic                sym_v_q;
    logic [1:0]          i_q;
    logic [1:0]          q_q;
    logic [1:0]          mem [DEPTH];
    logic [FIFO_AW-1:0]  wr_ptr;
    logic [FIFO_AW-1:0]  rd_ptr;
    logic [CW-1:0]       count;
    logic                empty;
    logic                full;
    logic                code_ok;
    logic                push;
    logic                drop;
    logic                pop;
    logic                last;
    logic [13:0]         bit_cnt;
    logic [13:0]         bit_cnt_nxt;
    logic [1:0]          hold;
    logic [1:0]          hold_nxt;
    logic                ser_o_nxt;
    logic                ser_valid_nxt;
    logic                strobe_nxt;

    // Input sample stage: decision-stage timing stays off the FIFO write path
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sym_v_q <= 1'b0;
            i_q     <= 2'b00;
            q_q     <= 2'b00;
        end else begin
            sym_v_q <= bus.sym_valid;
            i_q     <= bus.I_dec;
            q_q     <= bus.Q_dec;
        end
    end

`ifdef ERR_CHK_EN
    assign code_ok = i_q[0] & q_q[0];
`else
    logic unused_code;
    assign code_ok     = 1'b1;
    assign unused_code = i_q[0] ^ q_q[0];
`endif

    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));
    assign last  = (bit_cnt == BIT_CYCLES - 14'd1);
    assign push  = sym_v_q & code_ok & (~full | pop);
    assign drop  = sym_v_q & code_ok & full & ~pop;

    // Symbol FIFO: entry = {q_bit, i_bit}, occupancy held in count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < int'(DEPTH); k++) mem[k] <= 2'b00;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= {~q_q[1], ~i_q[1]};
                wr_ptr      <= wr_ptr + FIFO_AW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + FIFO_AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (!empty) state_nxt = OUT_Q;
            OUT_Q:   if (last)   state_nxt = OUT_I;
            OUT_I:   if (last)   state_nxt = empty ? IDLE : OUT_Q;
            default: state_nxt = IDLE;
        endcase
    end

    // Output/datapath decode; a pop always loads the Q bit straight from the FIFO head
    always_comb begin
        pop           = 1'b0;
        bit_cnt_nxt   = bit_cnt + 14'd1;
        hold_nxt      = hold;
        ser_o_nxt     = bus.ser_o;
        ser_valid_nxt = bus.ser_valid;
        strobe_nxt    = 1'b0;
        case (state)
            IDLE: begin
                bit_cnt_nxt   = 14'd0;
                ser_o_nxt     = 1'b0;
                ser_valid_nxt = 1'b0;
                if (!empty) begin
                    pop           = 1'b1;
                    hold_nxt      = mem[rd_ptr];
                    ser_o_nxt     = mem[rd_ptr][1];
                    ser_valid_nxt = 1'b1;
                    strobe_nxt    = 1'b1;
                end
            end
            OUT_Q: begin
                if (last) begin
                    bit_cnt_nxt = 14'd0;
                    ser_o_nxt   = hold[0];
                    strobe_nxt  = 1'b1;
                end
            end
            OUT_I: begin
                if (last) begin
                    bit_cnt_nxt = 14'd0;
                    if (!empty) begin
                        pop        = 1'b1;
                        hold_nxt   = mem[rd_ptr];
                        ser_o_nxt  = mem[rd_ptr][1];
                        strobe_nxt = 1'b1;
                    end else begin
                        ser_o_nxt     = 1'b0;
                        ser_valid_nxt = 1'b0;
                    end
                end
            end
            default: begin
                bit_cnt_nxt   = 14'd0;
                ser_o_nxt     = 1'b0;
                ser_valid_nxt = 1'b0;
            end
        endcase
    end

    // Q bit of the holding register is only needed for the pop itself
    logic unused_hold;
    assign unused_hold = hold[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt        <= 14'd0;
            hold           <= 2'b00;
            bus.ser_o      <= 1'b0;
            bus.ser_valid  <= 1'b0;
            bus.bit_strobe <= 1'b0;
            bus.ovf        <= 1'b0;
        end else begin
            bit_cnt        <= bit_cnt_nxt;
            hold           <= hold_nxt;
            bus.ser_o      <= ser_o_nxt;
            bus.ser_valid  <= ser_valid_nxt;
            bus.bit_strobe <= strobe_nxt;
            if (drop) bus.ovf <= 1'b1;
        end
    end

    // Invalid-code counter saturates at all ones
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.err_cnt <= 8'h00;
        end else begin
`ifdef ERR_CHK_EN
            if (sym_v_q && !code_ok && (bus.err_cnt != 8'hFF))
                bus.err_cnt <= bus.err_cnt + 8'd1;
`else
            bus.err_cnt <= 8'h00;
`endif
        end
    end
endmodule
